key_pulse_generator: RTL and testbench
======================================

// Module: key_pulse_generator
// PURPOSE
//  Opposite direction of the pulse extender: converts a long, noisy level (push-button/joystick line) into clean single-cycle
//  event pulses. Synchronises and debounces the raw input, emits one pulse per debounced press, and optionally auto-repeats while
//  held. Sits between board inputs and the game-control logic (player movement, menu stepping).
// PARAMETERS
//  DEBOUNCE_CYCLES      longint  500_000     stable cycles required to accept a press or release (>=1)
//  REPEAT_DELAY_CYCLES  longint  25_000_000  held cycles from accepted press to first repeat pulse (>=1)
//  REPEAT_PERIOD_CYCLES longint  5_000_000   cycles between subsequent repeat pulses (>=1)
//  REPEAT_EN            bit      1           1 = auto-repeat while held; 0 = one pulse per press
// PORTS
//  clk        in   1  system clock
//  resetN     in   1  synchronous, active-low reset
//  level_in   in   1  raw asynchronous input level, active-high
//  enable     in   1  1 = pulses allowed; 0 = pulse_out forced 0, tracking continues
//  pulse_out  out  1  single-cycle event pulse (press or repeat)
//  held       out  1  debounced level (1 from accepted press to accepted release)
//  repeating  out  1  1 while in auto-repeat phase (after first repeat pulse, until release accepted)
// BEHAVIOUR
//  - Reset (resetN=0 sampled on clk edge): state=IDLE, sync flops=0, all counters=0, pulse_out=0, held=0, repeating=0.
//  - level_in -> 2-flop synchroniser -> sync_q; FSM sees only sync_q. All outputs registered.
//  - Counters: db_cnt width $clog2(DEBOUNCE_CYCLES+1); rep_cnt width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1); down-counting, no wrap.
//  - pulse_out defaults to 0 every cycle; asserted exactly one cycle per event, and only if enable=1 at that edge.
//  - IDLE: sync_q=1 -> PRESS_DB, db_cnt=DEBOUNCE_CYCLES-1.
//  - PRESS_DB: sync_q=0 -> IDLE (glitch rejected, no pulse); else db_cnt==0 -> HELD, held=1, pulse_out=1,
//    rep_cnt=REPEAT_DELAY_CYCLES-1; else db_cnt--.
//  - HELD: sync_q=0 -> REL_DB, db_cnt=DEBOUNCE_CYCLES-1, rep_cnt frozen; else if REPEAT_EN && rep_cnt==0 -> pulse_out=1,
//    repeating=1, rep_cnt=REPEAT_PERIOD_CYCLES-1; else if REPEAT_EN rep_cnt--.
//  - REL_DB: sync_q=1 -> HELD (release rejected, rep_cnt resumes from frozen value, no pulse); else db_cnt==0 -> IDLE,
//    held=0, repeating=0; else db_cnt--. No pulses issued in REL_DB.
//  - Latency: level_in first sampled 1 at edge k, held steady -> pulse_out high in the cycle after edge k+DEBOUNCE_CYCLES+2.
//  - Glitch rule: level_in high for <=DEBOUNCE_CYCLES consecutive cycles -> no pulse. DEBOUNCE_CYCLES+1 cycles -> one pulse.
//  - Repeat timing: press pulse at edge E -> repeats at E+REPEAT_DELAY_CYCLES, then every REPEAT_PERIOD_CYCLES.
//  - DEBOUNCE_CYCLES=1: minimum debounce, no zero-width counter. REPEAT_EN=0: rep_cnt idle at 0; repeating never asserts.
//  - enable=0 at an event edge: that event is dropped, not deferred; repeat schedule still advances.
//  - Reset mid-operation (any state): returns to reset values next edge; an in-flight pulse_out drops to 0.
//    A level still high after reset is treated as a new press (full debounce, then pulse).
// STRUCTURE
//  - Shared package input_pkg: typedef enum logic [1:0] {KP_IDLE, KP_PRESS_DB, KP_HELD, KP_REL_DB} key_state_t;
//    default timing constants for 50 MHz (KEY_DB_10MS, KEY_RPT_DELAY_500MS, KEY_RPT_PERIOD_100MS).
//  - Sub-module sync_2ff (clk, resetN, d, q): reusable 2-flop synchroniser, sync reset to 0.
//  - Top: one FSM always_ff plus the two counters; no combinational output paths.
// TESTING  (bench params: DEBOUNCE=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_EN=1, enable=1 unless stated)
//  1 Clean press: level_in 0->1 at edge 0, held high -> pulse_out=1 for exactly one cycle after edge 6, held=1 from same
//    cycle; repeats after edges 16, 19, 22; repeating=1 from edge 16.
//  2 Glitch: level_in high 4 cycles then low -> no pulse_out, held stays 0. Width 5 -> exactly one pulse.
//  3 Release bounce: held, then level_in low 2 cycles, high again -> held stays 1, no extra pulse, repeat schedule resumes.
//    Low >=5 cycles -> held=0 and repeating=0 after debounce.
//  4 enable=0 during press edge -> no press pulse; raise enable before edge 16 -> repeat pulses at 16, 19 appear.
//  5 REPEAT_EN=0, hold level_in 100 cycles -> exactly one pulse_out, repeating never 1.
//  6 resetN=0 for 1 cycle while repeating, level_in held high -> outputs 0 next cycle; new press pulse 6 edges after reset release.

Source files
------------

// File: rtl/input_pkg.sv
// Shared types and timing defaults for board input conditioning.
// Key FSM state encoding plus 50 MHz debounce/repeat constants.
package input_pkg;

  typedef enum logic [1:0] {
    KP_IDLE,
    KP_PRESS_DB,
    KP_HELD,
    KP_REL_DB
  } key_state_t;

  localparam longint KEY_DB_10MS         = 500_000;
  localparam longint KEY_RPT_DELAY_500MS = 25_000_000;
  localparam longint KEY_RPT_PERIOD_100MS = 5_000_000;

  function automatic longint lmax(
    input longint a,
    input longint b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit level.
// Ports: clk, resetN (sync, active-low, clears to 0), d (async in), q (synced out).
module sync_2ff (
  input  logic clk,
  input  logic resetN,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_pulse_generator.sv
// Debounces a raw key level and emits single-cycle press/repeat pulses.
// Ports: clk, resetN (sync, active-low), level_in (async raw level),
//        enable (pulse gate), pulse_out (event), held, repeating.
module key_pulse_generator
  import input_pkg::*;
#(
  parameter longint DEBOUNCE_CYCLES      = KEY_DB_10MS,
  parameter longint REPEAT_DELAY_CYCLES  = KEY_RPT_DELAY_500MS,
  parameter longint REPEAT_PERIOD_CYCLES = KEY_RPT_PERIOD_100MS,
  parameter bit     REPEAT_EN            = 1'b1
) (
  input  logic clk,
  input  logic resetN,
  input  logic level_in,
  input  logic enable,
  output logic pulse_out,
  output logic held,
  output logic repeating
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam longint RMAX =
    lmax(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
  localparam int RPW = $clog2(RMAX + 1);

  localparam logic [DBW-1:0] DB_LOAD =
    DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPW-1:0] RD_LOAD =
    RPW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPW-1:0] RP_LOAD =
    RPW'(REPEAT_PERIOD_CYCLES - 1);

  logic sync_q;

  key_state_t     state_q, state_d;
  logic [DBW-1:0] db_q, db_d;
  logic [RPW-1:0] rep_q, rep_d;
  logic           held_q, held_d;
  logic           rpt_q, rpt_d;
  logic           pulse_q, pulse_d;
  logic           event_hit;

  sync_2ff u_sync (
    .clk    (clk),
    .resetN (resetN),
    .d      (level_in),
    .q      (sync_q)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= KP_IDLE;
      db_q    <= '0;
      rep_q   <= '0;
      held_q  <= 1'b0;
      rpt_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      rep_q   <= rep_d;
      held_q  <= held_d;
      rpt_q   <= rpt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    db_d      = db_q;
    rep_d     = rep_q;
    held_d    = held_q;
    rpt_d     = rpt_q;
    event_hit = 1'b0;
    unique case (state_q)
      KP_IDLE: begin
        if (sync_q) begin
          state_d = KP_PRESS_DB;
          db_d    = DB_LOAD;
        end
      end
      KP_PRESS_DB: begin
        if (!sync_q) begin
          state_d = KP_IDLE;
        end else if (db_q == '0) begin
          state_d   = KP_HELD;
          held_d    = 1'b1;
          event_hit = 1'b1;
          if (REPEAT_EN) rep_d = RD_LOAD;
        end else begin
          db_d = db_q - DBW'(1);
        end
      end
      KP_HELD: begin
        // rep_cnt stays frozen while a release is being debounced
        if (!sync_q) begin
          state_d = KP_REL_DB;
          db_d    = DB_LOAD;
        end else if (REPEAT_EN) begin
          if (rep_q == '0) begin
            event_hit = 1'b1;
            rpt_d     = 1'b1;
            rep_d     = RP_LOAD;
          end else begin
            rep_d = rep_q - RPW'(1);
          end
        end
      end
      KP_REL_DB: begin
        if (sync_q) begin
          state_d = KP_HELD;
        end else if (db_q == '0) begin
          state_d = KP_IDLE;
          held_d  = 1'b0;
          rpt_d   = 1'b0;
        end else begin
          db_d = db_q - DBW'(1);
        end
      end
      default: state_d = KP_IDLE;
    endcase
    // a gated event is dropped outright, the schedule still advances
    pulse_d = event_hit & enable;
  end

  assign pulse_out = pulse_q;
  assign held      = held_q;
  assign repeating = rpt_q;

endmodule

// File: tb/tb_key_pulse_generator.sv
// Directed bench for key_pulse_generator (DEBOUNCE=4, DELAY=10, PERIOD=3).
// Edge n is the posedge right after inputs for step n are driven.
module tb_key_pulse_generator;

  logic clk = 1'b0;
  logic resetN;
  logic level_in;
  logic enable;
  logic level2;
  logic pulse_out, held, repeating;
  logic pulse2, held2, rep2;

  int vectors = 0;
  int miscompares = 0;
  int npulse;
  int nrep;

  always #5 clk = ~clk;

  key_pulse_generator #(
    .DEBOUNCE_CYCLES      (4),
    .REPEAT_DELAY_CYCLES  (10),
    .REPEAT_PERIOD_CYCLES (3),
    .REPEAT_EN            (1'b1)
  ) dut (
    .clk       (clk),
    .resetN    (resetN),
    .level_in  (level_in),
    .enable    (enable),
    .pulse_out (pulse_out),
    .held      (held),
    .repeating (repeating)
  );

  key_pulse_generator #(
    .DEBOUNCE_CYCLES      (4),
    .REPEAT_DELAY_CYCLES  (10),
    .REPEAT_PERIOD_CYCLES (3),
    .REPEAT_EN            (1'b0)
  ) dut_norpt (
    .clk       (clk),
    .resetN    (resetN),
    .level_in  (level2),
    .enable    (1'b1),
    .pulse_out (pulse2),
    .held      (held2),
    .repeating (rep2)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step(
    input logic lv,
    input logic en,
    input logic rn
  );
    level_in = lv;
    enable   = en;
    resetN   = rn;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle(input string tag);
    repeat (14) step(1'b0, 1'b1, 1'b1);
    check({tag, "_held"}, 32'(held), 0);
    check({tag, "_rep"}, 32'(repeating), 0);
  endtask

  task automatic chk3(
    input string tag,
    input int    n,
    input logic  ep,
    input logic  eh,
    input logic  er
  );
    check($sformatf("%s_pulse_%0d", tag, n),
          32'(pulse_out), 32'(ep));
    check($sformatf("%s_held_%0d", tag, n),
          32'(held), 32'(eh));
    check($sformatf("%s_rep_%0d", tag, n),
          32'(repeating), 32'(er));
  endtask

  initial begin
    level2 = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk3("reset", 0, 1'b0, 1'b0, 1'b0);
    check("reset_pulse2", 32'(pulse2), 0);
    check("reset_held2", 32'(held2), 0);
    settle("init");

    // clean press, held through three repeats
    for (int n = 0; n <= 23; n++) begin
      step(1'b1, 1'b1, 1'b1);
      chk3("press", n,
           n == 6 || n == 16 || n == 19 || n == 22,
           n >= 6, n >= 16);
    end
    settle("rel1");

    // glitch of exactly DEBOUNCE cycles is rejected
    for (int n = 0; n <= 14; n++) begin
      step(n < 4, 1'b1, 1'b1);
      chk3("glitch4", n, 1'b0, 1'b0, 1'b0);
    end
    settle("rel2");

    // one cycle longer gives exactly one pulse
    for (int n = 0; n <= 14; n++) begin
      step(n < 5, 1'b1, 1'b1);
      chk3("glitch5", n, n == 6,
           n >= 6 && n < 11, 1'b0);
    end
    settle("rel3");

    // release bounce freezes then resumes the schedule
    for (int n = 0; n <= 34; n++) begin
      step(!(n == 9 || n == 10) && n <= 26,
           1'b1, 1'b1);
      chk3("bounce", n,
           n == 6 || n == 19 || n == 22 ||
           n == 25 || n == 28,
           n >= 6 && n < 33,
           n >= 19 && n < 33);
    end
    settle("rel4");

    // press event gated off, repeats after enable rises
    for (int n = 0; n <= 23; n++) begin
      step(1'b1, n >= 10, 1'b1);
      chk3("gate", n,
           n == 16 || n == 19 || n == 22,
           n >= 6, n >= 16);
    end
    settle("rel5");

    // no auto-repeat variant: one pulse for a long hold
    npulse = 0;
    nrep   = 0;
    level2 = 1'b1;
    for (int n = 0; n <= 99; n++) begin
      step(1'b0, 1'b1, 1'b1);
      check($sformatf("norpt_pulse_%0d", n),
            32'(pulse2), 32'(n == 6));
      if (pulse2) npulse++;
      if (rep2) nrep++;
    end
    check("norpt_count", 32'(npulse), 1);
    check("norpt_repeating", 32'(nrep), 0);
    check("norpt_held", 32'(held2), 1);
    level2 = 1'b0;
    settle("rel6");
    check("norpt_released", 32'(held2), 0);

    // reset while repeating, level stays high
    for (int n = 0; n <= 27; n++) begin
      step(1'b1, 1'b1, n != 17);
      chk3("rst", n,
           n == 6 || n == 16 || n == 24,
           (n >= 6 && n < 17) || n >= 24,
           n == 16);
    end
    settle("rel7");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
